title_sequencer: RTL and testbench
==================================

Name: title_sequencer

Overview:
- Frame-rate controller that sequences the title sprite and game phases: attract (blinking title), slide-out on start, play, and game-over hold.
- Sits between vga_sync (frame tick), the button debouncer, the game logic (game_over), and the title renderer.
- Drives the title's top row and its visibility gate.
- Also issues the one-cycle start pulse that launches game play.

Parameters:
- TITLE_Y0, 215, home top row of the title sprite (pixels)
- SLIDE_STEP, 8, pixels the title moves up per frame during slide-out
- BLINK_FRAMES, 30, frames per blink half-period in attract
- HOLD_FRAMES, 120, frames the game-over screen is held before returning to attract

Ports:
- clk  input  1  system/pixel clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse per video frame, from vga_sync
- btn_start  input  1  debounced start/flap button level, already synchronous to clk
- game_over  input  1  one-cycle pulse from game logic
- title_y  output  10  current top row of the title sprite; the renderer uses it in place of the fixed row
- title_visible  output  1  gate ANDed with the renderer's title_on
- game_active  output  1  high while in PLAY
- start_pulse  output  1  one-cycle pulse on entry to PLAY
- state  output  2  current phase: ATTRACT=0, SLIDE=1, PLAY=2, OVER=3

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset values: state=ATTRACT, title_y=TITLE_Y0, title_visible=1, game_active=0, start_pulse=0. Internal counters = 0, btn_q = 0.
- Reset has priority over all inputs and returns the block to these values from any state mid-operation.
- Button edge: btn_q registers btn_start every cycle. press = btn_start & ~btn_q.
  - Only rising edges act, so a button held across a state change never triggers anything.
- start_pulse defaults to 0 every cycle and is set for exactly one cycle as noted below.

ATTRACT:
- On frame_tick, blink_cnt increments.
- When blink_cnt == BLINK_FRAMES-1 and frame_tick, blink_cnt clears and title_visible toggles.
- On press, on any cycle (frame_tick not required), the next state is SLIDE.
  - title_visible is forced to 1, blink_cnt cleared, title_y unchanged (TITLE_Y0).
- A press on the same cycle as a blink wrap: the press wins, and visible=1.

SLIDE:
- Button and game_over are ignored.
- On frame_tick with title_y > SLIDE_STEP: title_y decreases by SLIDE_STEP.
- On frame_tick with title_y <= SLIDE_STEP:
  - title_y=0, title_visible=0, state=PLAY, game_active=1, start_pulse=1 for one cycle.
  - Saturates at 0; no 10-bit wrap.

PLAY:
- title_visible=0, game_active=1.
- On game_over: state=OVER, game_active=0, title_y=TITLE_Y0, title_visible=1, hold_cnt=0.
- game_over is ignored in every other state.

OVER:
- On frame_tick, hold_cnt increments.
- When hold_cnt == HOLD_FRAMES-1 and frame_tick: state=ATTRACT, blink_cnt=0, title_visible=1.
- Presses during OVER are ignored.

Width rules:
- blink_cnt and hold_cnt are sized by $clog2 of their parameter, minimum 1 bit.
- title_y arithmetic is done in 10 bits, guarded by the comparison above.

Decomposition:
- Shared package/header (included by top-level and bench): state encodings ATTRACT/SLIDE/PLAY/OVER, TITLE_Y0, and screen constants (640x480).
- One natural sub-module: frame_counter (frame_tick-enabled counter with clear and terminal-count flag).
  - Instantiated twice, for blink and hold.
- The FSM and title_y datapath stay in title_sequencer.

Test Plan:
- Reset, then 30 frame_ticks with no press -> title_visible 1 until the 30th tick, then 0. After 60 ticks -> 1 again. state stays 0.
- Press after 45 ticks (title hidden) -> the next cycle has state=1, title_visible=1, title_y=215.
  - The next 26 ticks give title_y 207, 199, ..., 7.
  - The 27th tick gives title_y=0, state=2, game_active=1, and start_pulse high for exactly one cycle.
- btn_start held high from ATTRACT through SLIDE and PLAY -> only one start_pulse. Holding into OVER→ATTRACT does not re-trigger SLIDE.
- game_over pulse while in ATTRACT and in SLIDE -> no state change.
  - game_over in PLAY -> state=3, title_y=215, title_visible=1.
  - After 120 ticks -> state=0. A press at tick 60 of OVER is ignored.
- Reset asserted mid-SLIDE (title_y=103) -> the next cycle has state=0, title_y=215, title_visible=1, game_active=0, start_pulse=0.
- Press on the same cycle as the 30th blink tick -> state=1, title_visible=1, blink_cnt=0.

Source files
------------

// File: rtl/title_sequencer_pkg.sv
// title_sequencer_pkg: phase encodings, title geometry and screen constants.
package title_sequencer_pkg;
  typedef enum logic [1:0] {ATTRACT = 2'd0, SLIDE = 2'd1, PLAY = 2'd2, OVER = 2'd3} phase_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TITLE_Y0_DEF = 215;
  localparam int SLIDE_STEP_DEF = 8;
  localparam int BLINK_FRAMES_DEF = 30;
  localparam int HOLD_FRAMES_DEF = 120;
endpackage

// File: rtl/title_sequencer_frame_counter.sv
// frame_counter: frame-enabled modulo-N counter with clear and terminal-count flag.
module frame_counter #(
  parameter int N = 30,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(N - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/title_sequencer.sv
// title_sequencer: attract/slide/play/over phase control and title sprite position.
module title_sequencer
  import title_sequencer_pkg::*;
#(
  parameter int TITLE_Y0 = TITLE_Y0_DEF,
  parameter int SLIDE_STEP = SLIDE_STEP_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       game_over,
  output logic [9:0] title_y,
  output logic       title_visible,
  output logic       game_active,
  output logic       start_pulse,
  output logic [1:0] state
);
  phase_t st, st_d;
  logic btn_q, press, blink_tc, hold_tc, slide_done;
  logic [9:0] title_y_d;
  logic visible_d, game_active_d;
  assign press = btn_start & ~btn_q;
  assign state = st;
  frame_counter #(.N(BLINK_FRAMES)) u_blink (
    .clk(clk), .rst(reset), .en(st == ATTRACT && frame_tick),
    .clr(st != ATTRACT || press), .tc(blink_tc)
  );
  frame_counter #(.N(HOLD_FRAMES)) u_hold (
    .clk(clk), .rst(reset), .en(st == OVER && frame_tick),
    .clr(st != OVER), .tc(hold_tc)
  );
  always_ff @(posedge clk)
    if (reset) st <= ATTRACT;
    else st <= st_d;
  always_comb begin
    slide_done = st == SLIDE && frame_tick && title_y <= 10'(SLIDE_STEP);
    st_d = (st == ATTRACT) ? (press ? SLIDE : ATTRACT) :
           (st == SLIDE)   ? (slide_done ? PLAY : SLIDE) :
           (st == PLAY)    ? (game_over ? OVER : PLAY) :
                             (hold_tc ? ATTRACT : OVER);
  end
  // The final slide step saturates at row 0 rather than wrapping the 10-bit row.
  always_comb begin
    title_y_d = (st == SLIDE && frame_tick) ? (slide_done ? 10'd0 : title_y - 10'(SLIDE_STEP)) :
                (st == PLAY && game_over)   ? 10'(TITLE_Y0) : title_y;
    visible_d = (st_d == PLAY) ? 1'b0 :
                (st == ATTRACT) ? (press | (title_visible ^ blink_tc)) : 1'b1;
    game_active_d = st_d == PLAY;
  end
  always_ff @(posedge clk)
    if (reset) begin
      btn_q <= 1'b0;
      title_y <= 10'(TITLE_Y0);
      title_visible <= 1'b1;
      game_active <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_q <= btn_start;
      title_y <= title_y_d;
      title_visible <= visible_d;
      game_active <= game_active_d;
      start_pulse <= slide_done;
    end
endmodule

// File: tb/tb_title_sequencer.sv
// tb_title_sequencer: directed plan scenarios plus randomized traffic against a phase-level model.
module tb_title_sequencer;
  import title_sequencer_pkg::*;
  logic clk = 0, reset = 1, frame_tick = 0, btn_start = 0, game_over = 0;
  logic [9:0] title_y;
  logic title_visible, game_active, start_pulse;
  logic [1:0] state;
  int tests = 0, fails = 0, sp_count = 0;
  int m_phase, m_y, m_vis, m_sp, m_blink, m_hold, m_btn_q;

  title_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
    .game_over(game_over), .title_y(title_y), .title_visible(title_visible),
    .game_active(game_active), .start_pulse(start_pulse), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_y = 215; m_vis = 1; m_sp = 0; m_blink = 0; m_hold = 0; m_btn_q = 0;
  endtask

  task automatic model_clock(input bit tk, input bit b, input bit go);
    bit press = b && !m_btn_q;
    m_btn_q = b;
    m_sp = 0;
    case (m_phase)
      0: if (press) begin
           m_phase = 1; m_vis = 1; m_blink = 0;
         end else if (tk) begin
           m_blink++;
           if (m_blink == 30) begin m_blink = 0; m_vis = 1 - m_vis; end
         end
      1: if (tk) begin
           if (m_y > 8) m_y -= 8;
           else begin m_y = 0; m_vis = 0; m_phase = 2; m_sp = 1; end
         end
      2: if (go) begin m_phase = 3; m_y = 215; m_vis = 1; m_hold = 0; end
      default: if (tk) begin
           m_hold++;
           if (m_hold == 120) begin m_phase = 0; m_blink = 0; m_vis = 1; end
         end
    endcase
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_phase);
    chk("title_y", int'(title_y), m_y);
    chk("title_visible", int'(title_visible), m_vis);
    chk("game_active", int'(game_active), int'(m_phase == 2));
    chk("start_pulse", int'(start_pulse), m_sp);
    if (start_pulse) sp_count++;
  endtask

  task automatic step(input bit tk, input bit b, input bit go);
    frame_tick = tk; btn_start = b; game_over = go;
    @(posedge clk);
    model_clock(tk, b, go);
    #1 compare_all();
  endtask

  task automatic do_reset(input bit tk, input bit b, input bit go);
    frame_tick = tk; btn_start = b; game_over = go; reset = 1;
    @(posedge clk);
    model_reset();
    #1 reset = 0;
    compare_all();
  endtask

  initial begin
    model_reset();
    do_reset(0, 0, 0);
    chk("rst_y", int'(title_y), 215);
    chk("rst_state", int'(state), 0);
    repeat (29) step(1, 0, 0);
    chk("blink_29_vis", int'(title_visible), 1);
    step(1, 0, 0);
    chk("blink_30_vis", int'(title_visible), 0);
    repeat (15) step(1, 0, 0);
    step(0, 1, 0);
    chk("press_state", int'(state), 1);
    chk("press_vis", int'(title_visible), 1);
    chk("press_y", int'(title_y), 215);
    step(0, 0, 0);
    repeat (26) step(1, 0, 0);
    chk("slide_26_y", int'(title_y), 7);
    step(1, 0, 0);
    chk("slide_end_state", int'(state), 2);
    chk("slide_end_pulse", int'(start_pulse), 1);
    chk("slide_end_y", int'(title_y), 0);
    step(0, 0, 0);
    chk("pulse_one_cycle", int'(start_pulse), 0);
    step(0, 0, 1);
    chk("over_state", int'(state), 3);
    chk("over_y", int'(title_y), 215);
    repeat (59) step(1, 0, 0);
    step(1, 1, 0);
    chk("over_press_ignored", int'(state), 3);
    repeat (60) step(1, 0, 0);
    chk("over_done_state", int'(state), 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("go_attract_ignored", int'(state), 0);

    // Button held from attract through play, over and back to attract.
    sp_count = 0;
    step(0, 1, 0);
    step(0, 1, 1);
    chk("go_slide_ignored", int'(state), 1);
    repeat (27) step(1, 1, 0);
    repeat (5) step(1, 1, 0);
    step(0, 1, 1);
    repeat (120) step(1, 1, 0);
    repeat (5) step(1, 1, 0);
    chk("held_back_attract", int'(state), 0);
    chk("held_one_pulse", sp_count, 1);
    step(0, 0, 0);

    // Reset in the middle of the slide.
    step(0, 1, 0);
    repeat (14) step(1, 0, 0);
    chk("mid_slide_y", int'(title_y), 103);
    do_reset(1, 0, 0);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_y", int'(title_y), 215);
    chk("mid_rst_vis", int'(title_visible), 1);
    chk("mid_rst_active", int'(game_active), 0);

    // Press coinciding with the blink wrap.
    repeat (29) step(1, 0, 0);
    step(1, 1, 0);
    chk("wrap_press_state", int'(state), 1);
    chk("wrap_press_vis", int'(title_visible), 1);
    step(0, 0, 0);

    for (int i = 0; i < 20000; i++) begin
      bit b = btn_start;
      if ($urandom_range(7) == 0) b = ~b;
      if ($urandom_range(2999) == 0) do_reset($urandom_range(1), b, $urandom_range(1));
      else step($urandom_range(3) == 0, b, $urandom_range(39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
